// File: rtl/adc_avg_filter.sv
// rtl/adc_avg_filter.sv - boxcar moving-average filter for ADC receiver samples
//
// Ports:
//   sclk        clock, rising-edge active
//   rst         asynchronous active-high reset
//   sample_in   DATA_W-bit sample, stable while sample_tick is high
//   sample_tick one sample per high cycle
//   clear       synchronous flush of the window (wins over sample_tick)
//   avg_out     registered truncated mean of the last 2^LOG2_N samples
//   avg_valid   one-cycle pulse when avg_out is updated
//   primed      high once the window holds 2^LOG2_N samples

module adc_avg_filter #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 3
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_tick,
    input  logic              clear,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              primed
);

    localparam int N     = 1 << LOG2_N;
    localparam int SUM_W = DATA_W + LOG2_N;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LOG2_N-1:0]   wr_ptr;
    logic [LOG2_N:0]     fill;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    sum_nxt;
    logic [DATA_W-1:0]   old;
    logic                accept;
    logic                out_pend;
    logic                out_pend_nxt;
    logic [DATA_W-1:0]   sample_buf [N];

    // While filling, the slot being overwritten holds stale (unreset) data,
    // so the subtracted value is forced to zero until the window is full.
    always_comb begin
        accept       = sample_tick && !clear;
        old          = (state == RUN) ? sample_buf[wr_ptr] : '0;
        sum_nxt      = sum + {{LOG2_N{1'b0}}, sample_in} - {{LOG2_N{1'b0}}, old};
        state_nxt    = state;
        out_pend_nxt = 1'b0;
        case (state)
            FILL: begin
                if (accept && fill == (LOG2_N + 1)'(N - 1)) begin
                    state_nxt    = RUN;
                    out_pend_nxt = 1'b1;
                end
            end
            RUN: begin
                out_pend_nxt = accept;
            end
            default: state_nxt = FILL;
        endcase
        if (clear) begin
            state_nxt    = FILL;
            out_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            wr_ptr   <= '0;
            fill     <= '0;
            sum      <= '0;
            out_pend <= 1'b0;
            primed   <= 1'b0;
        end else begin
            state    <= state_nxt;
            out_pend <= out_pend_nxt;
            primed   <= (state_nxt == RUN);
            if (clear) begin
                wr_ptr <= '0;
                fill   <= '0;
                sum    <= '0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                sum    <= sum_nxt;
                if (state == FILL) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    // Sample storage carries no reset; the old-value mux covers the fill phase.
    always_ff @(posedge sclk) begin
        if (accept) begin
            sample_buf[wr_ptr] <= sample_in;
        end
    end

    // Output stage presents the mean one cycle after the sum update.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            avg_out   <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= out_pend && !clear;
            if (out_pend && !clear) begin
                avg_out <= sum[SUM_W-1:LOG2_N];
            end
        end
    end

endmodule
